// File: rtl/sm83_seq.sv
// sm83_seq: T-cycle / M-cycle timing generator for the SM83 core.
// Drives one-hot T1..T4 phase strobes, the per-instruction M-cycle index and
// the single-tick mread/mwrite launch pulses for the bus interface. Owns the
// RUN/HALT/STOP power states.
// Optional build macro: SM83_SEQ_DBG_STALL_EN adds a dbg_stall input that
// freezes the phases at an M-cycle boundary, like STOP but without 'stopped'.
module sm83_seq #(
    parameter int unsigned MCYC_WIDTH = 3
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic                  ctl_mread,
    input  logic                  ctl_mwrite,
    input  logic                  ctl_mcyc_last,
    input  logic                  ctl_halt,
    input  logic                  ctl_stop,
    input  logic                  irq_pending,
    input  logic                  stop_wake,
`ifdef SM83_SEQ_DBG_STALL_EN
    input  logic                  dbg_stall,
`endif
    output logic                  t1,
    output logic                  t2,
    output logic                  t3,
    output logic                  t4,
    output logic [MCYC_WIDTH-1:0] mcyc,
    output logic                  mread,
    output logic                  mwrite,
    output logic                  halted,
    output logic                  stopped,
    output logic                  req_conflict
);

    typedef enum logic [1:0] {
        StRun,
        StHalt,
        StStop,
        StStall
    } state_e;

    localparam logic [3:0]            PhT1     = 4'b0001;
    localparam logic [3:0]            PhT4     = 4'b1000;
    localparam logic [MCYC_WIDTH-1:0] MCYC_MAX = '1;

    state_e                  state_q;
    logic [3:0]              phase_q;
    logic [MCYC_WIDTH-1:0]   mcyc_q;
    logic                    conflict_q;
    // Set while reset is held: the T4 shown during reset is not a real M-cycle
    // end, so the first edge after release must not act as a boundary.
    logic                    boot_q;
    logic                    stall_req;
    logic                    frozen;
    logic                    launch;

`ifdef SM83_SEQ_DBG_STALL_EN
    assign stall_req = dbg_stall;
`else
    assign stall_req = 1'b0;
`endif

    // Phase rotation, M-cycle index, power state and sticky conflict flag.
    always_ff @(posedge clk) begin
        if (reset) begin
            state_q    <= StRun;
            phase_q    <= PhT4;
            mcyc_q     <= '0;
            conflict_q <= 1'b0;
            boot_q     <= 1'b1;
        end else begin
            boot_q <= 1'b0;
            unique case (state_q)
                StRun: begin
                    phase_q <= {phase_q[2:0], phase_q[3]};
                    if (phase_q[3] && !boot_q) begin
                        if (ctl_mread && ctl_mwrite) begin
                            conflict_q <= 1'b1;
                        end
                        if (ctl_mcyc_last) begin
                            mcyc_q <= '0;
                        end else if (mcyc_q != MCYC_MAX) begin
                            mcyc_q <= mcyc_q + 1'b1;
                        end
                        if (ctl_stop) begin
                            state_q <= StStop;
                            phase_q <= PhT4;
                        end else if (stall_req) begin
                            state_q <= StStall;
                            phase_q <= PhT4;
                        end else if (ctl_halt) begin
                            state_q <= StHalt;
                            mcyc_q  <= '0;
                        end
                    end
                end
                StHalt: begin
                    phase_q <= {phase_q[2:0], phase_q[3]};
                    mcyc_q  <= '0;
                    if (phase_q[3] && irq_pending) begin
                        state_q <= StRun;
                    end
                end
                StStop: begin
                    if (stop_wake) begin
                        state_q <= StRun;
                        phase_q <= PhT1;
                    end
                end
                StStall: begin
                    if (!stall_req) begin
                        state_q <= StRun;
                        phase_q <= PhT1;
                    end
                end
                default: begin
                    state_q <= StRun;
                    phase_q <= PhT4;
                end
            endcase
        end
    end

    // Phase strobes are masked while frozen; bus launches only at a live RUN T4.
    always_comb begin
        frozen       = (state_q == StStop) || (state_q == StStall);
        t1           = phase_q[0] & ~frozen;
        t2           = phase_q[1] & ~frozen;
        t3           = phase_q[2] & ~frozen;
        t4           = phase_q[3] & ~frozen;
        launch       = phase_q[3] & (state_q == StRun) & ~reset & ~boot_q;
        mwrite       = launch & ctl_mwrite;
        mread        = launch & ctl_mread & ~ctl_mwrite;
        mcyc         = mcyc_q;
        halted       = (state_q == StHalt);
        stopped      = (state_q == StStop);
        req_conflict = conflict_q;
    end

endmodule

// File: tb/tb_sm83_seq.sv
// Self-checking bench for sm83_seq: a directed table for the reset/first
// M-cycles, hand sequences for HALT/STOP/saturation corners, then random
// stimulus compared every tick against a phase/mode reference model.
module tb_sm83_seq;

    localparam int MAXM = 7;
`ifdef SM83_SEQ_DBG_STALL_EN
    localparam bit STALL_EN = 1'b1;
`else
    localparam bit STALL_EN = 1'b0;
`endif

    logic       clk = 1'b0;
    logic       reset = 1'b1;
    logic       ctl_mread = 1'b0, ctl_mwrite = 1'b0, ctl_mcyc_last = 1'b0;
    logic       ctl_halt = 1'b0, ctl_stop = 1'b0, irq_pending = 1'b0, stop_wake = 1'b0;
    logic       dbg_stall = 1'b0;
    logic       t1, t2, t3, t4, mread, mwrite, halted, stopped, req_conflict;
    logic [2:0] mcyc;

    sm83_seq #(.MCYC_WIDTH(3)) dut (
        .clk          (clk),
        .reset        (reset),
        .ctl_mread    (ctl_mread),
        .ctl_mwrite   (ctl_mwrite),
        .ctl_mcyc_last(ctl_mcyc_last),
        .ctl_halt     (ctl_halt),
        .ctl_stop     (ctl_stop),
        .irq_pending  (irq_pending),
        .stop_wake    (stop_wake),
`ifdef SM83_SEQ_DBG_STALL_EN
        .dbg_stall    (dbg_stall),
`endif
        .t1           (t1),
        .t2           (t2),
        .t3           (t3),
        .t4           (t4),
        .mcyc         (mcyc),
        .mread        (mread),
        .mwrite       (mwrite),
        .halted       (halted),
        .stopped      (stopped),
        .req_conflict (req_conflict)
    );

    always #5 clk = ~clk;

    int vectors = 0;
    int miscompares = 0;

    // Reference model: phase number 1..4, power mode, M-cycle count.
    localparam int MRun = 0, MHalt = 1, MStop = 2, MStall = 3;
    int m_phase = 4;
    int m_mode  = MRun;
    int m_mcyc  = 0;
    bit m_conf  = 0;
    bit m_boot  = 1;

    task automatic model_edge();
        bit stall;
        stall = STALL_EN && dbg_stall;
        if (reset) begin
            m_phase = 4; m_mode = MRun; m_mcyc = 0; m_conf = 0; m_boot = 1;
        end else begin
            case (m_mode)
                MRun: begin
                    if (m_phase == 4 && !m_boot) begin
                        if (ctl_mread && ctl_mwrite) m_conf = 1;
                        m_mcyc = ctl_mcyc_last ? 0 : ((m_mcyc + 1 > MAXM) ? MAXM : m_mcyc + 1);
                        if (ctl_stop) m_mode = MStop;
                        else if (stall) m_mode = MStall;
                        else begin
                            if (ctl_halt) begin m_mode = MHalt; m_mcyc = 0; end
                            m_phase = 1;
                        end
                    end else begin
                        m_phase = m_phase % 4 + 1;
                    end
                end
                MHalt: begin
                    if (m_phase == 4 && irq_pending) m_mode = MRun;
                    m_phase = m_phase % 4 + 1;
                end
                MStop: if (stop_wake) begin m_mode = MRun; m_phase = 1; end
                default: if (!stall) begin m_mode = MRun; m_phase = 1; end
            endcase
            m_boot = 0;
        end
    endtask

    function automatic logic [11:0] model_word();
        logic [3:0] t;
        logic [2:0] mc;
        bit live;
        t    = (m_mode == MRun || m_mode == MHalt) ? 4'(1 << (m_phase - 1)) : 4'b0000;
        live = !reset && !m_boot && m_mode == MRun && m_phase == 4;
        mc   = 3'(m_mcyc);
        return {t, mc, live && ctl_mread && !ctl_mwrite, live && ctl_mwrite,
                m_mode == MHalt, m_mode == MStop, m_conf};
    endfunction

    function automatic logic [11:0] dut_word();
        return {t4, t3, t2, t1, mcyc, mread, mwrite, halted, stopped, req_conflict};
    endfunction

    task automatic step(input string nm);
        logic [11:0] got, exp;
        model_edge();
        @(posedge clk);
        #1;
        got = dut_word();
        exp = model_word();
        vectors++;
        if (got !== exp) begin
            miscompares++;
            $display("FAIL %s @%0t: got {t4..t1,mcyc,rd,wr,hlt,stp,cf}=%b want %b",
                     nm, $time, got, exp);
        end
    endtask

    task automatic chk(input string nm, input int got, input int exp);
        vectors++;
        if (got != exp) begin
            miscompares++;
            $display("FAIL %s @%0t: got %0d want %0d", nm, $time, got, exp);
        end
    endtask

    task automatic clear_ctl();
        ctl_mread = 0; ctl_mwrite = 0; ctl_mcyc_last = 0; ctl_halt = 0; ctl_stop = 0;
        irq_pending = 0; stop_wake = 0; dbg_stall = 0;
    endtask

    // Step until the model shows a live RUN T4, bounded.
    task automatic run_until_t4(input string nm);
        bit found;
        found = 0;
        for (int i = 0; i < 12; i++) begin
            if (m_mode == MRun && m_phase == 4 && !m_boot) begin
                found = 1;
                break;
            end
            step(nm);
        end
        chk({nm, "_reach_t4"}, int'(found), 1);
    endtask

    typedef struct {
        bit         rst, rd, wr;
        logic [3:0] t;
        int         mc;
        bit         erd, ewr, conf;
    } vec_t;

    function automatic vec_t mk(bit rst, bit rd, bit wr, logic [3:0] t, int mc,
                                bit erd, bit ewr, bit conf);
        vec_t v;
        v.rst = rst; v.rd = rd; v.wr = wr; v.t = t; v.mc = mc;
        v.erd = erd; v.ewr = ewr; v.conf = conf;
        return v;
    endfunction

    initial begin
        vec_t tbl[$];
        logic [11:0] got, exp;

        // Reset held three ticks, then T1..T4 x3 with mcyc 0,1,2, then a conflict.
        tbl.push_back(mk(1, 0, 0, 4'b1000, 0, 0, 0, 0));
        tbl.push_back(mk(1, 0, 0, 4'b1000, 0, 0, 0, 0));
        tbl.push_back(mk(1, 1, 0, 4'b1000, 0, 0, 0, 0));
        tbl.push_back(mk(0, 0, 0, 4'b0001, 0, 0, 0, 0));
        tbl.push_back(mk(0, 0, 0, 4'b0010, 0, 0, 0, 0));
        tbl.push_back(mk(0, 0, 0, 4'b0100, 0, 0, 0, 0));
        tbl.push_back(mk(0, 0, 0, 4'b1000, 0, 0, 0, 0));
        tbl.push_back(mk(0, 1, 0, 4'b0001, 1, 0, 0, 0));
        tbl.push_back(mk(0, 1, 0, 4'b0010, 1, 0, 0, 0));
        tbl.push_back(mk(0, 1, 0, 4'b0100, 1, 0, 0, 0));
        tbl.push_back(mk(0, 1, 0, 4'b1000, 1, 1, 0, 0));
        tbl.push_back(mk(0, 1, 0, 4'b0001, 2, 0, 0, 0));
        tbl.push_back(mk(0, 1, 0, 4'b0010, 2, 0, 0, 0));
        tbl.push_back(mk(0, 1, 0, 4'b0100, 2, 0, 0, 0));
        tbl.push_back(mk(0, 1, 0, 4'b1000, 2, 1, 0, 0));
        tbl.push_back(mk(0, 0, 0, 4'b0001, 3, 0, 0, 0));
        tbl.push_back(mk(0, 0, 0, 4'b0010, 3, 0, 0, 0));
        tbl.push_back(mk(0, 0, 0, 4'b0100, 3, 0, 0, 0));
        tbl.push_back(mk(0, 1, 1, 4'b1000, 3, 0, 1, 0));
        tbl.push_back(mk(0, 1, 1, 4'b0001, 4, 0, 0, 1));
        tbl.push_back(mk(0, 0, 0, 4'b0010, 4, 0, 0, 1));

        clear_ctl();
        foreach (tbl[i]) begin
            reset = tbl[i].rst; ctl_mread = tbl[i].rd; ctl_mwrite = tbl[i].wr;
            model_edge();
            @(posedge clk);
            #1;
            got = dut_word();
            exp = {tbl[i].t, 3'(tbl[i].mc), tbl[i].erd, tbl[i].ewr, 1'b0, 1'b0, tbl[i].conf};
            vectors++;
            if (got !== exp) begin
                miscompares++;
                $display("FAIL table[%0d]: got {t4..t1,mcyc,rd,wr,hlt,stp,cf}=%b want %b",
                         i, got, exp);
            end
        end

        // Conflict stays sticky, then only reset clears it.
        clear_ctl();
        for (int i = 0; i < 6; i++) step("conflict_hold");
        chk("conflict_sticky", int'(req_conflict), 1);
        reset = 1;
        step("reset");
        step("reset");
        chk("reset_t4", int'(t4), 1);
        chk("reset_conflict", int'(req_conflict), 0);
        reset = 0;

        // mcyc_last at mcyc=2 clears the index; then saturation.
        for (int i = 0; i < 12 && !(m_mcyc == 2 && m_phase == 4 && !m_boot); i++) step("to_m2");
        chk("at_m2_t4", int'(mcyc), 2);
        ctl_mcyc_last = 1;
        step("last");
        ctl_mcyc_last = 0;
        chk("last_clear", int'(mcyc), 0);
        chk("last_t1", int'(t1), 1);
        for (int i = 0; i < 40; i++) step("sat");
        chk("mcyc_sat", int'(mcyc), 7);

        // HALT: phases rotate, bus idle under requests, IRQ at T2 wakes.
        run_until_t4("halt");
        ctl_halt = 1;
        step("halt_enter");
        ctl_halt = 0;
        chk("halted", int'(halted), 1);
        chk("halt_mcyc", int'(mcyc), 0);
        for (int i = 0; i < 8; i++) begin
            ctl_mread = (i < 4); ctl_mwrite = (i >= 4);
            step("halt_req");
            chk("halt_no_launch", int'(mread | mwrite), 0);
        end
        clear_ctl();
        for (int i = 0; i < 4 && m_phase != 2; i++) step("halt_to_t2");
        chk("halt_at_t2", int'(t2), 1);
        irq_pending = 1;
        for (int i = 0; i < 4 && m_mode != MRun; i++) step("halt_wake");
        irq_pending = 0;
        chk("wake_halted", int'(halted), 0);
        chk("wake_mcyc", int'(mcyc), 0);
        chk("wake_t1", int'(t1), 1);

        // STOP: outputs frozen 20 ticks, one-tick wake resumes at T1.
        run_until_t4("stop");
        ctl_stop = 1;
        step("stop_enter");
        ctl_stop = 0;
        for (int i = 0; i < 20; i++) begin
            step("stop_hold");
            chk("stop_t_zero", int'({t4, t3, t2, t1}), 0);
        end
        chk("stopped", int'(stopped), 1);
        stop_wake = 1;
        step("stop_wake");
        stop_wake = 0;
        chk("stop_wake_t1", int'(t1), 1);
        chk("stop_wake_stopped", int'(stopped), 0);

        // Reset while stopped overrides the state.
        run_until_t4("stop2");
        ctl_stop = 1;
        step("stop2_enter");
        ctl_stop = 0;
        step("stop2_hold");
        reset = 1;
        step("stop2_reset");
        reset = 0;
        chk("stop_reset_t4", int'(t4), 1);
        chk("stop_reset_stopped", int'(stopped), 0);

`ifdef SM83_SEQ_DBG_STALL_EN
        run_until_t4("stall");
        dbg_stall = 1;
        for (int i = 0; i < 5; i++) begin
            step("stall_hold");
            chk("stall_t_zero", int'({t4, t3, t2, t1}), 0);
            chk("stall_not_stopped", int'(stopped), 0);
        end
        dbg_stall = 0;
        step("stall_resume");
        chk("stall_resume_t1", int'(t1), 1);
        run_until_t4("stall2");
        dbg_stall = 1;
        step("stall2");
        step("stall2");
        reset = 1;
        step("stall2_reset");
        reset = 0;
        dbg_stall = 0;
        chk("stall_reset_t4", int'(t4), 1);
`endif

        // Random stimulus against the model.
        for (int i = 0; i < 2000; i++) begin
            reset         = ($urandom_range(0, 63) == 0);
            ctl_mread     = 1'($urandom_range(0, 1));
            ctl_mwrite    = ($urandom_range(0, 3) == 0);
            ctl_mcyc_last = ($urandom_range(0, 3) == 0);
            ctl_halt      = ($urandom_range(0, 9) == 0);
            ctl_stop      = ($urandom_range(0, 19) == 0);
            irq_pending   = ($urandom_range(0, 3) == 0);
            stop_wake     = ($urandom_range(0, 7) == 0);
            dbg_stall     = ($urandom_range(0, 5) == 0);
            step("random");
        end

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule

// File: doc/sm83_seq.md
Name: sm83_seq

Overview:
- T-cycle/M-cycle timing generator for the SM83 core.
- Sits directly upstream of the CPU bus interface block.
- Produces one-hot phase strobes t1..t4, the per-instruction M-cycle index, and the single-tick mread/mwrite launch pulses the bus interface consumes.
- Owns the RUN/HALT/STOP power states: HALT keeps phases running with the bus idle; STOP freezes phases.

Parameters:
- MCYC_WIDTH, 3, width of the M-cycle index; the index saturates at 2^MCYC_WIDTH-1.

Ports:
- clk  input  1  core clock, one tick per T-state.
- reset  input  1  synchronous, active-high.
- t1, t2, t3, t4  output  1 each  one-hot phase strobes; all 0 in STOP.
- mcyc  output  MCYC_WIDTH  M-cycle index within the current instruction.
- mread  output  1  read-sequence launch; high only during t4.
- mwrite  output  1  write-sequence launch; high only during t4.
- ctl_mread  input  1  decoder requests a read for the next M-cycle.
- ctl_mwrite  input  1  decoder requests a write for the next M-cycle.
- ctl_mcyc_last  input  1  current M-cycle is the instruction's last.
- ctl_halt  input  1  enter HALT at the end of this M-cycle.
- ctl_stop  input  1  enter STOP at the end of this M-cycle.
- irq_pending  input  1  HALT wake source.
- stop_wake  input  1  STOP wake source (joypad).
- halted  output  1  state is HALT.
- stopped  output  1  state is STOP.
- req_conflict  output  1  sticky flag: ctl_mread and ctl_mwrite were both requested at one t4.

Behaviour:
- Phase register is one-hot over T1..T4. In RUN and HALT it advances T1→T2→T3→T4→T1 on every clk.
- Reset:
  - Phase forced to T4, so t4=1 while reset is held and t1/t2/t3=0.
  - mcyc=0; state=RUN; halted=0; stopped=0; req_conflict=0; mread=mwrite=0.
  - The first tick after reset release is T1.
- M-cycle boundary: a posedge with t4=1.
  - At the boundary, mcyc clears to 0 if ctl_mcyc_last=1; otherwise it increments, saturating at 2^MCYC_WIDTH-1.
- mread and mwrite are combinational:
  - mwrite = t4 & RUN & ctl_mwrite.
  - mread = t4 & RUN & ctl_mread & !ctl_mwrite. Write has priority.
  - Both are 0 during reset, HALT and STOP.
  - At most one of them is ever high, and neither is ever high outside t4.
- req_conflict sets at any t4 tick in RUN where ctl_mread=ctl_mwrite=1. Only reset clears it.
- State transitions are sampled only at an M-cycle boundary, in priority order:
  - RUN, ctl_stop=1 → STOP.
  - RUN, ctl_halt=1 (and ctl_stop=0) → HALT. mcyc is forced to 0 at this boundary.
  - HALT, irq_pending=1 → RUN. mcyc=0 at the next T1.
  - HALT, otherwise: stay in HALT. Phases keep rotating and mcyc is held at 0.
- STOP behaviour:
  - The phase register is held at T4, but t1..t4 are all driven 0.
  - mcyc is held.
  - stop_wake is sampled on every tick. When stop_wake=1 the block returns to RUN and the next tick is T1. t4 is not reasserted before that T1.
- halted = (state==HALT); stopped = (state==STOP). Both are registered and change on the same edge as the state.
- ctl_halt, ctl_stop and ctl_mcyc_last are ignored when t4=0.
- Reset in any state or phase takes effect at the next edge and overrides wakes and requests.

Optional Feature:
- Macro: SM83_SEQ_DBG_STALL_EN.
- With the macro defined:
  - An extra input dbg_stall (1 bit) is present.
  - dbg_stall=1 at an M-cycle boundary in RUN freezes the block exactly like STOP: t outputs 0, mcyc held, stopped stays 0.
  - Phases resume at T1 on the tick after dbg_stall returns to 0.
  - STOP entry takes priority over stall.
- Without the macro: the port is absent and the behaviour is identical to the macro defined with dbg_stall tied to 0.

Test Plan:
- Reset 3 ticks, then release; run 12 ticks → t4=1 during reset; then T1,T2,T3,T4 repeats three times exactly one-hot; mcyc goes 0,1,2.
- ctl_mread=1 held for 8 ticks → mread high only on the two t4 ticks; mwrite stays 0. ctl_mread=ctl_mwrite=1 → only mwrite pulses; req_conflict=1 and stays 1 until reset.
- ctl_mcyc_last=1 at a t4 with mcyc=2 → mcyc=0 from the next T1. 10 M-cycles without ctl_mcyc_last (MCYC_WIDTH=3) → mcyc saturates at 7.
- ctl_halt at t4 → halted=1, phases keep rotating, mread/mwrite stay 0 under requests. irq_pending asserted at a T2 → halted drops at the next boundary; mcyc=0.
- ctl_stop at t4 → t1..t4 all 0 for 20 ticks, stopped=1. stop_wake pulsed 1 tick → t1=1 on the next tick; stopped=0.
- With SM83_SEQ_DBG_STALL_EN: dbg_stall high 5 ticks from a boundary → t outputs 0 and mcyc frozen for 5 ticks, then resumes at T1. Reset during stall → t4=1 next tick.
